// File: rtl/mem_bus_bridge_pkg.sv
// Shared defines for the memory-stage bus bridge: bus widths, common words,
// FSM encoding and the captured request record.
package mem_bus_bridge_pkg;

  localparam int RegBus  = 32;
  localparam int SelBus  = 4;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [RegBus-1:0] WordMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } bridge_state_e;

  // Request fields latched from the memory stage when an access starts
  typedef struct packed {
    logic              we;
    logic [RegBus-1:0] addr;
    logic [SelBus-1:0] sel;
    logic [RegBus-1:0] wdata;
  } bus_req_t;

  // Force a byte address onto its containing word
  function automatic logic [RegBus-1:0] word_align(input logic [RegBus-1:0] a);
    return a & WordMask;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter for an outstanding bus access. Counts enabled cycles and
// flags the cycle whose increment would reach TIMEOUT.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count waiting cycles; saturate at TIMEOUT so a stuck enable cannot wrap
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && (cnt != CW'(TIMEOUT)))
      cnt <= cnt + 1'b1;
  end

  // This cycle's increment lands on TIMEOUT, so the access gives up now
  always_comb expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges a single memory-stage access onto a request/ack bus: capture in
// IDLE, hold the request in BUSY until ack/err/timeout, release in DONE.
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [RegBus-1:0] addr_i,
  input  logic [SelBus-1:0] sel_i,
  input  logic [RegBus-1:0] wdata_i,
  output logic [RegBus-1:0] rdata_o,
  output logic              stall_req_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [RegBus-1:0] bus_addr_o,
  output logic [SelBus-1:0] bus_sel_o,
  output logic [RegBus-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [RegBus-1:0] bus_rdata_i
);

  bridge_state_e state, nxt;
  bus_req_t      req_q;
  logic          in_busy;
  logic          start;
  logic          cnt_en;
  logic          expired;
  logic          abort;

  // A response of either kind stops the wait counter
  always_comb begin
    in_busy = (state == ST_BUSY);
    start   = (state == ST_IDLE) && ce_i;
    cnt_en  = in_busy && !bus_ack_i && !bus_err_i;
    abort   = in_busy && (bus_err_i || expired);
  end

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .en      (cnt_en),
    .expired (expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next state; DONE never looks at ce_i so a held enable cannot reissue
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (ce_i) nxt = ST_BUSY;
      ST_BUSY: if (bus_ack_i || bus_err_i || expired) nxt = ST_DONE;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Latch the request fields at the start of an access; they stay frozen
  // for the whole BUSY interval
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
    end else if (start) begin
      req_q.we    <= we_i;
      req_q.addr  <= word_align(addr_i);
      req_q.sel   <= sel_i;
      req_q.wdata <= wdata_i;
    end
  end

  // Read data: error/timeout zeroes it (error wins over a same-cycle ack),
  // load ack captures the bus word, store ack leaves it alone
  always_ff @(posedge clk) begin
    if (rst)
      rdata_o <= ZeroWord;
    else if (abort)
      rdata_o <= ZeroWord;
    else if (in_busy && bus_ack_i && !req_q.we)
      rdata_o <= bus_rdata_i;
  end

  // Error flag is registered so it is high exactly for the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) err_o <= 1'b0;
    else     err_o <= abort;
  end

  // Bus qualifiers only live in BUSY; stall follows ce_i while idle
  always_comb begin
    bus_req_o   = in_busy;
    bus_we_o    = in_busy && req_q.we;
    bus_sel_o   = in_busy ? req_q.sel : '0;
    bus_addr_o  = req_q.addr;
    bus_wdata_o = req_q.wdata;
    stall_req_o = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: stall_req_o = ce_i;
        ST_BUSY: stall_req_o = 1'b1;
        default: stall_req_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge with TIMEOUT=4. Inputs change 1ns after
// the rising edge; outputs are checked 2ns after it, mid-cycle.
module tb_mem_bus_bridge;

  logic        clk;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  sel_i;
  logic [31:0] rdata_o;
  logic        stall_req_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  int total = 0;
  int bad   = 0;

  mem_bus_bridge #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce_i        (ce_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .sel_i       (sel_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_req_o (stall_req_o),
    .err_o       (err_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_sel_o   (bus_sel_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_err_i   (bus_err_i),
    .bus_rdata_i (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    int nreq;
    logic prev_req;
    logic [7:0] exp_req;

    rst = 1'b1; ce_i = 1'b1; we_i = 1'b0; addr_i = '0; sel_i = '0; wdata_i = '0;
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;

    // Reset state, with ce_i high to show stall is masked under reset
    tick(); tick();
    settle();
    chk("rst_stall", stall_req_o, 0);
    chk("rst_req",   bus_req_o, 0);
    chk("rst_we",    bus_we_o, 0);
    chk("rst_sel",   bus_sel_o, 0);
    chk("rst_err",   err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr",  bus_addr_o, 0);
    chk("rst_wdata", bus_wdata_o, 0);

    // Load, ack with no wait states
    tick(); rst = 1'b0; ce_i = 1'b0;
    tick(); ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0106; sel_i = 4'b0010;
    bus_rdata_i = 32'hA1B2_C3D4;
    settle();
    chk("ld_stall_idle", stall_req_o, 1);
    chk("ld_req_idle",   bus_req_o, 0);
    tick(); ce_i = 1'b0; bus_ack_i = 1'b1;
    settle();
    chk("ld_stall_busy", stall_req_o, 1);
    chk("ld_req_busy",   bus_req_o, 1);
    chk("ld_addr",       bus_addr_o, 32'h0000_0104);
    chk("ld_sel",        bus_sel_o, 4'b0010);
    chk("ld_we",         bus_we_o, 0);
    tick(); bus_ack_i = 1'b0;
    settle();
    chk("ld_stall_done", stall_req_o, 0);
    chk("ld_req_done",   bus_req_o, 0);
    chk("ld_rdata",      rdata_o, 32'hA1B2_C3D4);
    chk("ld_err",        err_o, 0);
    tick();
    settle();
    chk("ld_rdata_hold", rdata_o, 32'hA1B2_C3D4);

    // Store, ack after three wait states: cycles 2..5 BUSY, 6 DONE
    tick(); ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0203; sel_i = 4'b0100;
    wdata_i = 32'h5A5A_5A5A; bus_rdata_i = 32'hDEAD_BEEF;
    settle();
    chk("st_stall_c1", stall_req_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); ce_i = 1'b0; wdata_i = 32'h0; addr_i = 32'hFFFF_FFFF; sel_i = 4'hF;
      bus_ack_i = (i == 3);
      settle();
      chk("st_req",   bus_req_o, 1);
      chk("st_we",    bus_we_o, 1);
      chk("st_sel",   bus_sel_o, 4'b0100);
      chk("st_addr",  bus_addr_o, 32'h0000_0200);
      chk("st_wdata", bus_wdata_o, 32'h5A5A_5A5A);
      chk("st_stall", stall_req_o, 1);
    end
    tick(); bus_ack_i = 1'b0;
    settle();
    chk("st_stall_c6", stall_req_o, 0);
    chk("st_req_done", bus_req_o, 0);
    chk("st_we_done",  bus_we_o, 0);
    chk("st_sel_done", bus_sel_o, 0);
    chk("st_rdata",    rdata_o, 32'hA1B2_C3D4);

    // Timeout: no response for four BUSY cycles
    tick(); ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0400; sel_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick(); ce_i = 1'b0;
      settle();
      chk("to_req_busy", bus_req_o, 1);
      chk("to_err_busy", err_o, 0);
    end
    tick();
    settle();
    chk("to_err_done", err_o, 1);
    chk("to_rdata",    rdata_o, 0);
    chk("to_req_done", bus_req_o, 0);
    tick();
    settle();
    chk("to_err_clr",  err_o, 0);

    // Load again so rdata is non-zero, then error+ack together
    tick(); ce_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    tick(); ce_i = 1'b0; bus_ack_i = 1'b1;
    tick(); bus_ack_i = 1'b0;
    settle();
    chk("pre_err_rdata", rdata_o, 32'h1111_2222);
    tick(); ce_i = 1'b1; addr_i = 32'h0000_0300; sel_i = 4'hF;
    tick(); ce_i = 1'b0; bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'h1234_5678;
    settle();
    chk("er_req_busy", bus_req_o, 1);
    chk("er_err_busy", err_o, 0);
    tick(); bus_ack_i = 1'b0; bus_err_i = 1'b0;
    settle();
    chk("er_err_done", err_o, 1);
    chk("er_rdata",    rdata_o, 0);
    chk("er_stall",    stall_req_o, 0);
    tick();
    settle();
    chk("er_err_clr",  err_o, 0);
    chk("er_idle_req", bus_req_o, 0);
    ce_i = 1'b1;
    settle();
    chk("er_idle_stall", stall_req_o, 1);
    tick(); ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_00AA;
    settle();
    chk("er_new_req", bus_req_o, 1);
    tick(); bus_ack_i = 1'b0;

    // Reset in the second BUSY cycle, then a stray late ack
    tick(); ce_i = 1'b1; addr_i = 32'h0000_0500;
    tick(); ce_i = 1'b0;
    settle();
    chk("rb_req_b1", bus_req_o, 1);
    tick(); rst = 1'b1;
    settle();
    chk("rb_req_b2",   bus_req_o, 1);
    chk("rb_stall_rst", stall_req_o, 0);
    tick(); rst = 1'b0;
    settle();
    chk("rb_req_after", bus_req_o, 0);
    chk("rb_rdata",     rdata_o, 0);
    chk("rb_addr",      bus_addr_o, 0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    tick(); bus_ack_i = 1'b0;
    settle();
    chk("rb_late_req",   bus_req_o, 0);
    chk("rb_late_rdata", rdata_o, 0);
    chk("rb_late_stall", stall_req_o, 0);
    chk("rb_late_err",   err_o, 0);

    // Back-to-back loads with ce_i held: IDLE BUSY DONE IDLE BUSY DONE IDLE IDLE
    exp_req = 8'b0001_0010;
    nreq = 0; prev_req = 1'b0;
    tick(); ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0600; bus_ack_i = 1'b1;
    bus_rdata_i = 32'h0BAD_CAFE;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      if (c == 5) ce_i = 1'b0;
      settle();
      chk("b2b_req", bus_req_o, exp_req[c]);
      if (bus_req_o && !prev_req) nreq++;
      prev_req = bus_req_o;
      if (c == 2) begin
        chk("b2b_done_stall", stall_req_o, 0);
        chk("b2b_rdata",      rdata_o, 32'h0BAD_CAFE);
      end
    end
    chk("b2b_count", nreq, 2);
    bus_ack_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of BUSY cycles waited for bus_ack_i before abort.
REQ-002 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 ce_i  input  1  SHALL be the memory-stage chip enable; 1 means a data access is requested this cycle.
REQ-005 we_i  input  1  SHALL be the write enable from the memory stage (1 store, 0 load).
REQ-006 addr_i  input  32  SHALL be the byte address from the memory stage.
REQ-007 sel_i  input  4  SHALL be the byte-lane select from the memory stage.
REQ-008 wdata_i  input  32  SHALL be the store data, lane-replicated by the memory stage.
REQ-009 rdata_o  output  32  SHALL be the word returned to the memory stage for load extraction.
REQ-010 stall_req_o  output  1  SHALL be the stall request to pipeline control.
REQ-011 err_o  output  1  SHALL be a one-cycle pulse flagging bus error or timeout.
REQ-012 bus_req_o, bus_we_o  output  1 each  SHALL be the bus request and write qualifier.
REQ-013 bus_addr_o  output  32, bus_sel_o  output  4, bus_wdata_o  output  32  SHALL be the registered bus request fields.
REQ-014 bus_ack_i, bus_err_i  input  1 each; bus_rdata_i  input  32  SHALL be the bus response.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-016 In IDLE with ce_i=1, the block SHALL capture we_i, {addr_i[31:2],2'b00}, sel_i and wdata_i, clear the timeout counter, and move to BUSY.
REQ-017 stall_req_o SHALL equal ce_i in IDLE (combinational), 1 in BUSY and 0 in DONE.
REQ-018 In BUSY, bus_req_o SHALL be 1, and the bus fields SHALL hold the captured values, stable until the state is left.
REQ-019 In BUSY with bus_ack_i=1, the block SHALL load rdata_o with bus_rdata_i on loads, leave rdata_o unchanged on stores, and move to DONE.
REQ-020 In BUSY with bus_err_i=1, the block SHALL set rdata_o to 0, pulse err_o in DONE and move to DONE; if bus_err_i and bus_ack_i are both 1, bus_err_i SHALL win.
REQ-021 In BUSY with no response, the counter SHALL increment; when it equals TIMEOUT, the block SHALL abort as in REQ-020.
REQ-022 DONE SHALL last exactly one cycle with bus_req_o=0 and rdata_o held, then return to IDLE; ce_i is ignored during DONE, so no request is reissued.
REQ-023 Minimum load/store latency SHALL be 3 cycles: IDLE capture, BUSY with ack, DONE release.
REQ-024 bus_ack_i or bus_err_i arriving outside BUSY SHALL be ignored.
REQ-025 In any state other than BUSY, bus_req_o, bus_we_o and bus_sel_o SHALL be 0.

Reset
REQ-026 On rst=1 at a clock edge, state SHALL go to IDLE, and rdata_o, bus_addr_o, bus_wdata_o and the counter SHALL be cleared to 0.
REQ-027 On reset, bus_req_o, bus_we_o, bus_sel_o and err_o SHALL be 0, and stall_req_o SHALL be 0 while rst=1.
REQ-028 Reset during BUSY SHALL drop bus_req_o on the next edge without waiting for bus_ack_i.

Structure
REQ-029 The FSM state encoding and the bus-width constants SHALL live in the shared defines file, alongside RegBus and ZeroWord.
REQ-030 The timeout counter SHALL be a sub-module bus_timeout_cnt with clear, enable, TIMEOUT compare and expired output.

Verification
REQ-031 Load, ack after 0 waits: ce_i=1, we_i=0, addr_i=0x00000106, sel_i=4'b0010, bus_rdata_i=0xA1B2C3D4 -> bus_addr_o=0x00000104, rdata_o=0xA1B2C3D4 in DONE, stall_req_o=1,1,0.
REQ-032 Store, ack after 3 waits: wdata_i=0x5A5A5A5A, sel_i=4'b0100 -> bus_req_o high 4 cycles with fields stable, bus_we_o=1, stall released cycle 6.
REQ-033 Bus error: bus_err_i=1 and bus_ack_i=1 in the same cycle -> rdata_o=0, err_o pulses once, FSM returns to IDLE.
REQ-034 Timeout with TIMEOUT=4 and no ack -> abort after 4 BUSY cycles, err_o=1 for one cycle, rdata_o=0.
REQ-035 rst asserted in the 2nd BUSY cycle -> bus_req_o=0 next cycle; a late bus_ack_i leaves state IDLE and rdata_o=0.
REQ-036 Back-to-back loads with ce_i held high -> exactly two bus requests, separated by one DONE cycle.
